// File: rtl/wb_block_reader.sv
// Wishbone block reader: fetches count_i consecutive words from base_adr_i, one transaction at a time,
// and hands each word out on a valid/ready port. Define WB_READER_TIMEOUT_EN to enable the WAIT-state timeout.
module wb_block_reader #(
  parameter int ADR_W     = 8,
  parameter int TIMEOUT   = 15,
  parameter int RETRY_MAX = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [ADR_W-1:0] base_adr_i,
  input  logic [ADR_W-2:0] count_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic             wb_we_o,
  output logic [3:0]       wb_sel_o,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic             wb_rty_i,
  input  logic             wb_stall_i,
  output logic [31:0]      dat_o,
  output logic             dat_valid_o,
  input  logic             dat_ready_i
);

  localparam int WA_W  = ADR_W - 2;
  localparam int CNT_W = ADR_W - 1;
  localparam int RTY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WA_W-1:0]   adr_q, adr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [31:0]       dat_q, dat_d;
  logic              err_q, err_d;
  logic              resp_en;
  logic              tmo_hit;
  logic [1:0]        unused_adr_lsb;

  assign unused_adr_lsb = base_adr_i[1:0];

`ifdef WB_READER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;

  // Held at zero outside WAIT, so it always starts from zero on entry.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)               tmo_q <= '0;
    else if (state_q != WAIT)   tmo_q <= '0;
    else                        tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_hit = (state_q == WAIT) && (tmo_q == TMO_W'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      rem_q   <= '0;
      retry_q <= '0;
      dat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      rem_q   <= rem_d;
      retry_q <= retry_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
    end
  end

  // Output port handshake: a word transfers on a cycle where dat_valid_o and
  // dat_ready_i are both high; while dat_valid_o is high and dat_ready_i is low,
  // dat_o is held and the bus stays idle.
  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    rem_d       = rem_q;
    retry_d     = retry_q;
    dat_d       = dat_q;
    err_d       = err_q;
    resp_en     = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    dat_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          adr_d   = base_adr_i[ADR_W-1:2];
          rem_d   = count_i;
          retry_d = '0;
          err_d   = 1'b0;
          state_d = (count_i == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        busy_o   = 1'b1;
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        // A response is only meaningful in the cycle the strobe is accepted.
        resp_en  = !wb_stall_i;
        if (!wb_stall_i) state_d = WAIT;
      end
      WAIT: begin
        busy_o   = 1'b1;
        wb_cyc_o = 1'b1;
        resp_en  = 1'b1;
      end
      OUT: begin
        busy_o      = 1'b1;
        dat_valid_o = 1'b1;
        if (dat_ready_i) begin
          adr_d   = adr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          retry_d = '0;
          state_d = (rem_q == CNT_W'(1)) ? DONE : REQ;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Response priority is err > ack > rty; timeout only fires with no response.
    if (resp_en) begin
      if (wb_err_i) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else if (wb_ack_i) begin
        dat_d   = wb_dat_i;
        state_d = OUT;
      end else if (wb_rty_i) begin
        if (retry_q == RTY_W'(RETRY_MAX)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          retry_d = retry_q + 1'b1;
          state_d = REQ;
        end
      end else if (tmo_hit) begin
        err_d   = 1'b1;
        state_d = DONE;
      end
    end
  end

  assign wb_adr_o = {adr_q, 2'b00};
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'b1111;
  assign dat_o    = dat_q;
  assign err_o    = err_q;

endmodule

// File: doc/wb_block_reader.md
WB_BLOCK_READER -- requirements
Module: wb_block_reader

Interface
REQ-001 The module SHALL have one clock and one reset: the reset is synchronous and active-low, and the ports are named clk_i and rst_n_i.
REQ-002 Parameter ADR_W SHALL default to 8 and give the byte-address width; bits [1:0] are always 0.
REQ-003 Parameter TIMEOUT SHALL default to 15 and give the maximum number of WAIT cycles before an error.
REQ-004 Parameter RETRY_MAX SHALL default to 3 and give the number of rty re-issues allowed per word.
REQ-005 The ports SHALL be:
- clk_i  in  1  clock
- rst_n_i  in  1  sync active-low reset
- start_i  in  1  one-cycle start pulse
- base_adr_i  in  ADR_W  byte start address; bits [1:0] ignored
- count_i  in  ADR_W-1  number of words
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky error flag
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_adr_o  out  ADR_W  Wishbone address
- wb_we_o  out  1  constant 0
- wb_sel_o  out  4  constant 4'b1111
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  bus error
- wb_rty_i  in  1  retry
- wb_stall_i  in  1  pipelined stall
- dat_o  out  32  captured word
- dat_valid_o  out  1  dat_o valid
- dat_ready_i  in  1  consumer accepts

Function
REQ-006 The FSM SHALL have the states IDLE, REQ, WAIT, OUT and DONE; only one Wishbone transaction is outstanding at a time.
REQ-007 In IDLE, start_i=1 SHALL latch base_adr_i[ADR_W-1:2] and count_i, clear err_o, and go to REQ; if count_i=0, go to DONE instead.
REQ-008 REQ SHALL assert wb_cyc_o and wb_stb_o; while wb_stall_i=1 it stays in REQ, and when wb_stall_i=0 it goes to WAIT with stb=0 next cycle and cyc held.
REQ-009 The first wb_cyc_o/wb_stb_o SHALL appear the cycle after start_i.
REQ-010 In WAIT, wb_ack_i SHALL register wb_dat_i into dat_o, drop cyc, and go to OUT; dat_valid_o is high the following cycle.
REQ-011 wb_ack_i, wb_err_i and wb_rty_i SHALL be honoured in REQ in the cycle stb is accepted, and in WAIT.
REQ-012 When more than one response is asserted in the same cycle, the priority SHALL be err > ack > rty.
REQ-013 wb_err_i SHALL set err_o, drop cyc/stb, and go to DONE; the remaining words are abandoned.
REQ-014 wb_rty_i SHALL re-enter REQ with the same address and increment the retry counter; rty number RETRY_MAX+1 on the same word is treated as wb_err_i.
REQ-015 In OUT, dat_valid_o SHALL stay high and dat_o stable until dat_ready_i=1.
REQ-016 On that OUT handshake, the word address SHALL increment by 1 modulo 2^(ADR_W-2) (wrap from 0xFC to 0x00 for ADR_W=8), the remaining count decrement, and the retry counter clear.
REQ-017 After the OUT handshake, the FSM SHALL go to REQ if the remaining count is nonzero, else to DONE.
REQ-018 DONE SHALL last exactly one cycle, pulse done_o, and return to IDLE.
REQ-019 busy_o SHALL be 1 in REQ, WAIT and OUT, and 0 in IDLE and DONE.
REQ-020 start_i outside IDLE SHALL be ignored.
REQ-021 Responses arriving in OUT, DONE or IDLE SHALL be ignored.

Reset
REQ-022 With rst_n_i=0 at a clk_i edge, the FSM SHALL go to IDLE, and every output SHALL go to 0 except wb_sel_o=4'b1111: cyc, stb, adr, busy, done, err, dat_o and dat_valid_o.
REQ-023 A reset mid-transfer SHALL drop cyc/stb at that edge with no done_o pulse.

Configuration
REQ-024 With WB_READER_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and count WAIT cycles; after TIMEOUT cycles with no response, the block behaves as wb_err_i (err_o=1, DONE).
REQ-025 Without WB_READER_TIMEOUT_EN, WAIT SHALL last indefinitely, and no counter logic is present.

Verification
REQ-026 start base=0x10, count=3; always-ready slave ack after 1 cycle; dat_ready_i=1 -> reads at 0x10, 0x14, 0x18; three dat_valid_o beats; one done_o; err_o=0.
REQ-027 base=0xF8, count=3 -> addresses 0xF8, 0xFC, 0x00.
REQ-028 stall=1 for 4 cycles, then dat_ready_i=0 for 5 cycles -> stb held 5 cycles; dat_o stable; address not advanced until handshake.
REQ-029 rty on word 0 twice, then ack -> 0x10 issued three times; err_o=0; if rty is given 4 times -> err_o=1, done_o pulse, no data beat.
REQ-030 err and ack asserted together on word 1 of 3 -> err_o=1, done_o; only word 0 delivered; WB_READER_TIMEOUT_EN with no response -> err_o=1 after 15 WAIT cycles.
REQ-031 count=0 -> no cyc; done_o the cycle after start; rst_n_i=0 during WAIT -> cyc=0 next edge; no done_o.
